seq_event_window_counter: RTL and testbench
===========================================

Name: seq_event_window_counter

Overview:
- Downstream consumer of the 101/001 sequence detector's registered Y and Z detect pulses.
- Counts Y and Z events over a programmable window of clock cycles (bit times).
- Latches the counts into result registers and presents them with a valid/ack handshake to a control or status reader.
- Supports single-shot and back-to-back (continuous) windows, with overrun flagging.

Parameters:
- WINDOW, 32, samples per window (≥1).
- CW, 4, width of each event count; counts saturate at 2^CW-1.

Ports:
- clk  input  1  clock; all state updates on the falling edge, same edge as the detector stage.
- resetn  input  1  asynchronous active-low reset.
- y_in  input  1  detector Y pulse (101 detected), one sample per clock.
- z_in  input  1  detector Z pulse (001 detected), one sample per clock.
- start  input  1  begin a window; honoured only in IDLE.
- cont  input  1  continuous mode, sampled at each window end.
- ack  input  1  reader accepts the current result.
- y_count  output  CW  latched Y count of the last completed window.
- z_count  output  CW  latched Z count of the last completed window.
- valid  output  1  result registers hold unread data.
- overrun  output  1  sticky: an unread result was overwritten.
- busy  output  1  high while in COUNT.

Behaviour:
- All registers update on negedge clk and clear asynchronously on negedge resetn.
- Reset values: state=IDLE; y_count=0, z_count=0, valid=0, overrun=0, busy=0; internal accumulators and window counter=0.
- Reset asserted mid-window discards the window and any pending result. After release, the block waits in IDLE for start.
- FSM has 2 states, IDLE and COUNT; busy = (state==COUNT).
- IDLE, start=1 at an edge:
  - go to COUNT; clear accumulators and the window counter (width clog2(WINDOW), minimum 1); clear overrun.
  - y_in/z_in on this edge are not counted.
- COUNT:
  - each edge samples y_in and z_in; each accumulator increments by 1 when its input is 1 and it is below 2^CW-1, else holds.
  - y_in=z_in=1 on the same edge increments both.
  - start is ignored.
- Window end is the WINDOW-th sampling edge after the start edge. On that edge:
  - y_count/z_count load the accumulator values including that edge's sample;
  - valid becomes 1;
  - if cont=1, the block stays in COUNT with accumulators and window counter cleared, and the next edge is sample 1 of the new window (no gap);
  - if cont=0, the block returns to IDLE.
- Latency: valid is first visible after the WINDOW-th falling edge following the start edge.
- Handshake:
  - valid=1 and ack=1 at an edge without a window end: valid clears.
  - ack while valid=0 has no effect.
- Window end at an edge where valid=1:
  - ack=1 on the same edge: new data loads, valid stays 1, no overrun;
  - ack=0: new data overwrites the old, valid stays 1, overrun sets.
- overrun is sticky; only reset or an accepted start clears it.
- Result registers hold their value while the next window is counting.

Decomposition:
- Shared package seq_det_pkg: FSM state encodings (IDLE=1'b0, COUNT=1'b1), default constants for WINDOW and CW.
- Sub-module sat_counter (parameter W; inputs clk, resetn, clr, inc; output q): synchronous clear with priority over inc, increment saturating at 2^W-1.
  - Instantiated twice, for the Y and Z accumulators.

Test Plan:
1. Basic window: reset, start at edge 0, y_in=1 on samples 3,7,10,20,31, z_in=1 on samples 5,6,32 -> valid rises after edge 32 with y_count=5, z_count=3, busy=0; ack next edge -> valid=0.
2. Saturation: y_in held 1 for all 32 samples -> y_count=15, z_count=0; both inputs 1 on 4 samples only -> y_count=4, z_count=4.
3. Continuous with no ack:
   - cont=1, window 1 has 2 Y events, window 2 has 6 Y events, no ack -> after edge 64 y_count=6, valid=1, overrun=1, busy still 1.
   - then start while busy -> ignored.
4. ack coincident with window end: cont=1, ack=1 on edge 64 -> valid=1, overrun=0, y_count equals the window-2 count.
5. Reset mid-operation: resetn low at sample 17 -> all outputs 0 immediately (asynchronous); after release, y_in pulses with no start -> valid stays 0, busy=0.
6. Start edge exclusion: y_in=1 only on the start edge and z_in=1 only on the edge after window end with cont=0 -> y_count=0, z_count=0, state IDLE.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared definitions for the sequence-detector event window counter.
package seq_det_pkg;

   // Two-state control FSM: waiting for start, or sampling a window.
   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_e;

   localparam int unsigned DEF_WINDOW = 32;
   localparam int unsigned DEF_CW     = 4;

   // Width of the window sample counter; never narrower than one bit.
   function automatic int unsigned win_cnt_width(input int unsigned window);
      return (window > 1) ? $clog2(window) : 1;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; updates on the falling edge.
module sat_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q, q_d;

   // Next value: clear wins over increment; increment stops at all-ones.
   always_comb begin
      // NOTE: default first so every path assigns q_d and no latch is inferred.
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (inc && (q_q != {W{1'b1}})) begin
         q_d = q_q + W'(1);
      end
   end

   // Count register, falling-edge clocked like the detector it follows.
   always_ff @(negedge clk or negedge resetn) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (!resetn) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/seq_event_window_counter.sv
// Counts detector Y/Z pulses over a fixed window and hands the result to a
// reader through a valid/ack handshake, flagging unread results that get
// overwritten.
module seq_event_window_counter
   import seq_det_pkg::*;
#(
   parameter int unsigned WINDOW = DEF_WINDOW,
   parameter int unsigned CW     = DEF_CW
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          y_in,
   input  logic          z_in,
   input  logic          start,
   input  logic          cont,
   input  logic          ack,
   output logic [CW-1:0] y_count,
   output logic [CW-1:0] z_count,
   output logic          valid,
   output logic          overrun,
   output logic          busy
);

   localparam int unsigned      WCW     = win_cnt_width(WINDOW);
   localparam logic [WCW-1:0]   LAST    = WCW'(WINDOW - 1);
   localparam logic [CW-1:0]    SAT_MAX = {CW{1'b1}};

   state_e          state_q, state_d;
   logic [WCW-1:0]  win_q, win_d;
   logic [CW-1:0]   y_cnt_q, y_cnt_d;
   logic [CW-1:0]   z_cnt_q, z_cnt_d;
   logic            valid_q, valid_d;
   logic            overrun_q, overrun_d;

   logic [CW-1:0]   y_acc, z_acc;
   logic [CW-1:0]   y_acc_next, z_acc_next;
   logic            counting, start_acc, win_end, acc_clr;

   assign counting  = (state_q == COUNT);
   assign start_acc = (state_q == IDLE) && start;
   assign win_end   = counting && (win_q == LAST);
   // Accumulators restart on an accepted start and at every window end.
   assign acc_clr   = start_acc || win_end;

   // The result includes the final edge's sample, so look one step ahead.
   assign y_acc_next = y_acc + CW'(y_in && (y_acc != SAT_MAX));
   assign z_acc_next = z_acc + CW'(z_in && (z_acc != SAT_MAX));

   sat_counter #(.W(CW)) u_y_acc (
      .clk    (clk),
      .resetn (resetn),
      .clr    (acc_clr),
      .inc    (counting && y_in),
      .q      (y_acc)
   );

   sat_counter #(.W(CW)) u_z_acc (
      .clk    (clk),
      .resetn (resetn),
      .clr    (acc_clr),
      .inc    (counting && z_in),
      .q      (z_acc)
   );

   // FSM, window counter and result/handshake next-state logic.
   always_comb begin
      state_d   = state_q;
      win_d     = win_q;
      y_cnt_d   = y_cnt_q;
      z_cnt_d   = z_cnt_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = COUNT;
               win_d     = '0;
               overrun_d = 1'b0;
            end
         end
         COUNT: begin
            if (win_q == LAST) begin
               win_d = '0;
               if (!cont) begin
                  state_d = IDLE;
               end
            end else begin
               win_d = win_q + WCW'(1);
            end
         end
      endcase

      // A window end always publishes; an ack on that edge retires the old data.
      if (win_end) begin
         y_cnt_d = y_acc_next;
         z_cnt_d = z_acc_next;
         valid_d = 1'b1;
         if (valid_q && !ack) begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && ack) begin
         valid_d = 1'b0;
      end
   end

   // Control and result registers.
   always_ff @(negedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         win_q     <= '0;
         y_cnt_q   <= '0;
         z_cnt_q   <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         win_q     <= win_d;
         y_cnt_q   <= y_cnt_d;
         z_cnt_q   <= z_cnt_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign y_count = y_cnt_q;
   assign z_count = z_cnt_q;
   assign valid   = valid_q;
   assign overrun = overrun_q;
   assign busy    = counting;

endmodule

// File: tb/tb_seq_event_window_counter.sv
// Self-checking bench for seq_event_window_counter. Inputs change just after
// the rising edge; the DUT acts on the falling edge; outputs are read after
// the following rising edge.
module tb_seq_event_window_counter;

   localparam int W  = 32;
   localparam int CW = 4;

   logic          clk = 1'b1;
   logic          resetn = 1'b0;
   logic          y_in = 1'b0, z_in = 1'b0;
   logic          start = 1'b0, cont = 1'b0, ack = 1'b0;
   logic [CW-1:0] y_count, z_count;
   logic          valid, overrun, busy;

   typedef struct {
      string         tag;
      logic [CW-1:0] y;
      logic [CW-1:0] z;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   seq_event_window_counter #(.WINDOW(W), .CW(CW)) dut (
      .clk     (clk),
      .resetn  (resetn),
      .y_in    (y_in),
      .z_in    (z_in),
      .start   (start),
      .cont    (cont),
      .ack     (ack),
      .y_count (y_count),
      .z_count (z_count),
      .valid   (valid),
      .overrun (overrun),
      .busy    (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One DUT falling edge, then settle on the next rising edge.
   task automatic edge_step();
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   // Independent expectation: number of set samples, clipped at the count limit.
   function automatic logic [CW-1:0] sat_count(input logic [W:1] v);
      int n = 0;
      int lim = (1 << CW) - 1;
      for (int i = 1; i <= W; i++) if (v[i]) n++;
      return (n > lim) ? CW'(lim) : CW'(n);
   endfunction

   task automatic apply_reset();
      resetn = 1'b0;
      y_in = 1'b0; z_in = 1'b0; start = 1'b0; cont = 1'b0; ack = 1'b0;
      edge_step();
      resetn = 1'b1;
   endtask

   task automatic do_start();
      start = 1'b1;
      edge_step();
      start = 1'b0;
   endtask

   task automatic ack_result(input string tag);
      ack = 1'b1;
      edge_step();
      ack = 1'b0;
      check({tag, "/valid_after_ack"}, valid, 1'b0);
   endtask

   // Drive one full window; sample s of the pattern is bit s.
   task automatic run_window(input string tag, input logic [W:1] yp, input logic [W:1] zp,
                             input logic cont_v, input logic ack_end, input logic start_s1,
                             input logic pre_valid);
      exp_t e;
      e.tag = tag;
      e.y   = sat_count(yp);
      e.z   = sat_count(zp);
      sb_q.push_back(e);
      for (int s = 1; s <= W; s++) begin
         y_in  = yp[s];
         z_in  = zp[s];
         cont  = cont_v;
         ack   = (s == W) ? ack_end : 1'b0;
         start = (s == 1) ? start_s1 : 1'b0;
         edge_step();
         if (s == W - 1) check({tag, "/valid_before_end"}, valid, pre_valid);
      end
      y_in = 1'b0; z_in = 1'b0; cont = 1'b0; ack = 1'b0; start = 1'b0;
   endtask

   task automatic pop_result();
      exp_t e;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_empty: got no pending entry expected one");
      end else begin
         e = sb_q.pop_front();
         check({e.tag, "/valid"}, valid, 1'b1);
         check({e.tag, "/y_count"}, y_count, e.y);
         check({e.tag, "/z_count"}, z_count, e.z);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [W:1] yp, zp;

      // 1. Basic window
      apply_reset();
      check("rst/y_count", y_count, 0);
      check("rst/z_count", z_count, 0);
      check("rst/valid", valid, 0);
      check("rst/overrun", overrun, 0);
      check("rst/busy", busy, 0);
      do_start();
      check("t1/busy_started", busy, 1);
      yp = 32'h4008_0244;
      zp = 32'h8000_0030;
      run_window("t1", yp, zp, 1'b0, 1'b0, 1'b0, 1'b0);
      pop_result();
      check("t1/y_is_5", y_count, 5);
      check("t1/busy_end", busy, 0);
      check("t1/overrun", overrun, 0);
      ack_result("t1");
      check("t1/y_hold", y_count, 5);
      ack = 1'b1;
      edge_step();
      ack = 1'b0;
      check("t1/ack_idle_valid", valid, 0);

      // 2. Saturation
      do_start();
      yp = 32'hFFFF_FFFF;
      zp = '0;
      run_window("t2a", yp, zp, 1'b0, 1'b0, 1'b0, 1'b0);
      pop_result();
      check("t2a/y_sat", y_count, 15);
      ack_result("t2a");
      do_start();
      yp = 32'h0001_1011;
      zp = 32'h0001_1011;
      run_window("t2b", yp, zp, 1'b0, 1'b0, 1'b0, 1'b0);
      pop_result();
      check("t2b/overrun", overrun, 0);
      ack_result("t2b");

      // 3. Continuous, no ack, then start while busy
      apply_reset();
      do_start();
      run_window("t3w1", 32'h0000_0003, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      pop_result();
      check("t3w1/busy", busy, 1);
      check("t3w1/overrun", overrun, 0);
      run_window("t3w2", 32'h0000_3F00, '0, 1'b1, 1'b0, 1'b0, 1'b1);
      pop_result();
      check("t3w2/overrun", overrun, 1);
      check("t3w2/busy", busy, 1);
      run_window("t3w3", 32'h0000_0011, '0, 1'b0, 1'b0, 1'b1, 1'b1);
      pop_result();
      check("t3w3/overrun_kept", overrun, 1);
      check("t3w3/busy", busy, 0);

      // 4. ack coincident with window end
      apply_reset();
      do_start();
      run_window("t4w1", 32'h0000_0007, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      pop_result();
      run_window("t4w2", 32'h0000_00F0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
      pop_result();
      check("t4w2/overrun", overrun, 0);
      check("t4w2/busy", busy, 1);

      // 5. Reset in the middle of a window
      apply_reset();
      do_start();
      run_window("t5w1", 32'h0000_0007, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0);
      pop_result();
      cont = 1'b1;
      y_in = 1'b1;
      for (int s = 1; s <= 16; s++) edge_step();
      check("t5/y_hold_mid", y_count, 3);
      check("t5/busy_mid", busy, 1);
      resetn = 1'b0;
      #1;
      check("t5/async_y", y_count, 0);
      check("t5/async_z", z_count, 0);
      check("t5/async_valid", valid, 0);
      check("t5/async_busy", busy, 0);
      edge_step();
      resetn = 1'b1;
      for (int s = 1; s <= 40; s++) begin
         y_in = 1'b1;
         z_in = s[0];
         edge_step();
      end
      y_in = 1'b0; z_in = 1'b0; cont = 1'b0;
      check("t5/no_start_valid", valid, 0);
      check("t5/no_start_busy", busy, 0);

      // 6. Start edge and post-window edge are not counted
      apply_reset();
      y_in = 1'b1;
      do_start();
      y_in = 1'b0;
      run_window("t6", '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      pop_result();
      check("t6/busy", busy, 0);
      z_in = 1'b1;
      edge_step();
      z_in = 1'b0;
      check("t6/y_after", y_count, 0);
      check("t6/z_after", z_count, 0);
      check("t6/busy_after", busy, 0);
      check("t6/valid_after", valid, 1);

      check("scoreboard_drained", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
